// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: fetch and data requester handshakes plus the memory-side bus.
// The arbiter connects through the slave view; requesters and memory use the master view.
interface mem_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_done;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_done;
   logic [31:0] d_rdata;

   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_rdata;

   logic        busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output i_done, i_rdata, d_done, d_rdata, m_addr, m_wdata, m_read, m_write, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  i_done, i_rdata, d_done, d_rdata, m_addr, m_wdata, m_read, m_write, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Each access: one ACCESS phase of WAIT+1 cycles on latched values, then a RESP cycle with a done pulse.
module mem_port_arbiter #(
   parameter int WAIT = 0
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        last;
   logic        owner;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] i_rdata_q;
   logic [31:0] d_rdata_q;
   logic        i_done_q;
   logic        d_done_q;

   logic        any_req;
   logic        grant_d;
   logic        final_cycle;

   // On a tie the requester that was not served last wins.
   always_comb begin
      any_req     = bus.i_req | bus.d_req;
      grant_d     = bus.d_req & (~bus.i_req | (last == OWN_I));
      final_cycle = (state == S_ACCESS) && (cnt == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         last      <= OWN_D;
         owner     <= OWN_I;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  state     <= S_ACCESS;
                  owner     <= grant_d;
                  last      <= grant_d;
                  lat_addr  <= grant_d ? bus.d_addr : bus.i_addr;
                  lat_wdata <= grant_d ? bus.d_wdata : 32'd0;
                  lat_we    <= grant_d & bus.d_we;
                  cnt       <= 4'(WAIT);
               end
            end
            S_ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Read data is taken from the last ACCESS cycle only.
                  if (!lat_we) begin
                     if (owner == OWN_D) d_rdata_q <= bus.m_rdata;
                     else                i_rdata_q <= bus.m_rdata;
                  end
                  if (owner == OWN_D) d_done_q <= 1'b1;
                  else                i_done_q <= 1'b1;
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Write strobe is gated by reset so an aborted store never commits.
   assign bus.m_addr  = lat_addr;
   assign bus.m_wdata = lat_wdata;
   assign bus.m_read  = (state == S_ACCESS) & ~lat_we;
   assign bus.m_write = final_cycle & lat_we & ~reset;
   assign bus.busy    = (state != S_IDLE);
   assign bus.i_done  = i_done_q;
   assign bus.d_done  = d_done_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequenced, round-robin arbiter that shares the CPU's single memory port between the instruction-fetch requester (read-only) and the data requester (read/write). It latches the winning request and drives the memory for `WAIT`+1 cycles, issuing exactly one write pulse per store. It then returns read data and a one-cycle done pulse to the owner. It sits between the fetch/data stages of the datapath and the `mem` instance, and lets the multi-cycle core stall on `busy`.

## Interface
- `WAIT`, default 0: extra wait-state cycles per access, legal range 0..15.
- `clk`  in  1  the single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_req`  in  1  fetch request (level); held with `i_addr` until `i_done`.
- `i_addr`  in  32  fetch byte address.
- `i_done`  out  1  one-cycle pulse: fetch complete, `i_rdata` valid.
- `i_rdata`  out  32  registered fetch data; holds until next fetch completes.
- `d_req`  in  1  data request (level); held with `d_we`/`d_addr`/`d_wdata` until `d_done`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_done`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  32  registered load data; unchanged by writes.
- `m_addr`  out  32  memory address (latched copy).
- `m_wdata`  out  32  memory write data (latched copy).
- `m_read`  out  1  memory read enable.
- `m_write`  out  1  memory write enable; memory commits on the `clk` edge ending a cycle with `m_write`=1.
- `m_rdata`  in  32  memory read data, combinational from `m_addr`.
- `busy`  out  1  1 whenever state ≠ IDLE.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE → ACCESS**: if any request is high, grant, latch `addr`/`wdata`/`we`/`owner`, load `cnt` = `WAIT`.
  - A fetch latches `we` = 0.
- **ACCESS**:
  - `m_addr`/`m_wdata` come from the latches.
  - `m_read` = ~`we`.
  - `m_write` = `we` & (`cnt` == 0) & ~`reset`, giving exactly one pulse per write, in the last ACCESS cycle.
  - If `cnt` ≠ 0, decrement `cnt`.
  - If `cnt` == 0, on a read capture `m_rdata` into the owner's rdata register, set the owner's done for the next cycle, and go to RESP.
- **RESP**: the owner's done = 1. Requests are ignored. Next state is always IDLE.
- **Arbitration**:
  - A single requester wins immediately.
  - If both request in IDLE, grant the one not served last.
  - The `last` register resets to D, so I wins the first tie.
  - `last` updates on every grant.
- Requesters keep `req` high during RESP only if issuing a new access. `req` is sampled again in the following IDLE cycle.
- Input changes during ACCESS/RESP have no effect because the access uses latched values.
- Outside ACCESS, `m_read` = `m_write` = 0, and `m_addr`/`m_wdata` show the last latched values.
- `cnt` is 4 bits; no wrap is possible within the legal `WAIT` range.
- **Reset values**:
  - State IDLE, `cnt` 0, `last` = D, `owner` 0.
  - Latched addr/wdata/we = 0.
  - `i_rdata` = `d_rdata` = 0, `i_done` = `d_done` = 0, `busy` = 0.
  - `m_addr` = `m_wdata` = 0, `m_read` = `m_write` = 0.
- **Reset mid-operation**: abort; no done pulse for the aborted access. `m_write` is gated by `reset` combinationally, so a write whose final ACCESS cycle coincides with `reset` does not commit.

## Timing
- Request sampled in IDLE cycle T:
  - ACCESS occupies cycles T+1 .. T+1+`WAIT`.
  - Done pulses at T+2+`WAIT`.
  - IDLE again at T+3+`WAIT`.
- Throughput is one access per `WAIT`+3 cycles.
- `m_addr` and `m_wdata` are stable for all `WAIT`+1 ACCESS cycles.
- The read data captured is `m_rdata` from the final ACCESS cycle.
- `i_done` and `d_done` are never high in the same cycle, and each is high for exactly one cycle.
- `busy` rises at T+1 and falls at T+3+`WAIT`.

## Test plan
- **Reset**: assert `reset` 2 cycles with random inputs → every output 0, `busy` 0, no `m_write`.
- **Single fetch, `WAIT`=0**: `i_req`=1, `i_addr`=0x40, memory returns 0x8C220004 → `m_read`=1 and `m_addr`=0x40 at T+1; `i_done`=1 with `i_rdata`=0x8C220004 at T+2; `busy` 0 at T+3.
- **Contention**: both requests held high from reset for 4 accesses → grant order I, D, I, D; done pulses 3 cycles apart; never both dones in one cycle.
- **Write, `WAIT`=2**: `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF → `m_addr`/`m_wdata` stable T+1..T+3; `m_write`=1 only at T+3; `d_done` at T+4; `d_rdata` unchanged; memory word 0x100 = 0xDEADBEEF.
- **Input change mid-access**: change `d_addr` 0x100 → 0x200 at T+2 with `WAIT`=2 → `m_addr` stays 0x100 through T+3.
- **Reset during final write cycle**: `WAIT`=1, `reset`=1 at T+2 → `m_write` stays 0; memory word unchanged; no `d_done`; `busy` 0 at T+3; next request is granted normally.
